// File: rtl/dlsc_mt9v032_pkg.sv
// Shared types and constants for the MT9V032 per-camera pixel path.
// Pixel width, full-scale value and the tagged-pixel record.
package dlsc_mt9v032_pkg;

   localparam int PX_BITS = 10;
   localparam logic [PX_BITS-1:0] PX_MAX = 10'h3FF;

   typedef struct packed {
      logic [PX_BITS-1:0] data;
      logic               first;
      logic               last_col;
      logic               last_row;
   } px_tag_t;

endpackage

// File: rtl/dlsc_mt9v032_raster_cnt.sv
// Raster position tracker: x/y counters that step once per accepted pixel,
// exposing the position flags of the pixel about to be accepted.
module dlsc_mt9v032_raster_cnt #(
   parameter int HDISP = 752,
   parameter int VDISP = 480
) (
   input  logic px_clk,
   input  logic px_rst_n,
   input  logic advance,
   input  logic clear,
   output logic first,
   output logic last_col,
   output logic last_row,
   output logic eof
);

   localparam int X_BITS = $clog2(HDISP);
   localparam int Y_BITS = $clog2(VDISP);
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(HDISP - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(VDISP - 1);

   logic [X_BITS-1:0] x_q, x_d;
   logic [Y_BITS-1:0] y_q, y_d;

   assign first    = (x_q == '0) && (y_q == '0);
   assign last_col = (x_q == X_LAST);
   assign last_row = (y_q == Y_LAST);
   assign eof      = last_col && last_row;

   // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (advance) begin
         if (last_col) begin
            x_d = '0;
            y_d = last_row ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge px_clk or negedge px_rst_n) begin
      if (!px_rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/dlsc_mt9v032_framer.sv
// Per-camera framer: tags each pixel with raster flags through a single
// output register stage and publishes per-frame min/max/sum at end of frame.
module dlsc_mt9v032_framer
   import dlsc_mt9v032_pkg::*;
#(
   parameter int HDISP     = 752,
   parameter int VDISP     = 480,
   parameter int SUM_BITS  = 29,
   parameter int FCNT_BITS = 16
) (
   input  logic                 px_clk,
   input  logic                 px_rst_n,
   input  logic                 sync_clear,
   output logic                 in_ready,
   input  logic                 in_valid,
   input  logic [PX_BITS-1:0]   in_data,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [PX_BITS-1:0]   out_data,
   output logic                 out_first,
   output logic                 out_last_col,
   output logic                 out_last_row,
   output logic                 stat_valid,
   output logic [PX_BITS-1:0]   stat_min,
   output logic [PX_BITS-1:0]   stat_max,
   output logic [SUM_BITS-1:0]  stat_sum,
   output logic [FCNT_BITS-1:0] stat_frame
);

   logic accept;
   logic r_first, r_last_col, r_last_row, r_eof;

   px_tag_t              out_q, out_d;
   logic                 out_valid_q, out_valid_d;
   logic [PX_BITS-1:0]   min_q, min_d, max_q, max_d;
   logic [SUM_BITS-1:0]  sum_q, sum_d;
   logic [PX_BITS-1:0]   stat_min_q, stat_min_d, stat_max_q, stat_max_d;
   logic [SUM_BITS-1:0]  stat_sum_q, stat_sum_d;
   logic [FCNT_BITS-1:0] stat_frame_q, stat_frame_d;
   logic                 stat_valid_q, stat_valid_d;

   logic [PX_BITS-1:0]   px_min, px_max;
   logic [SUM_BITS-1:0]  px_sum;

   assign in_ready = !sync_clear && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   dlsc_mt9v032_raster_cnt #(
      .HDISP (HDISP),
      .VDISP (VDISP)
   ) u_raster (
      .px_clk   (px_clk),
      .px_rst_n (px_rst_n),
      .advance  (accept),
      .clear    (sync_clear),
      .first    (r_first),
      .last_col (r_last_col),
      .last_row (r_last_row),
      .eof      (r_eof)
   );

   // Running statistics including the pixel being accepted this cycle.
   assign px_min = (in_data < min_q) ? in_data : min_q;
   assign px_max = (in_data > max_q) ? in_data : max_q;
   assign px_sum = sum_q + SUM_BITS'(in_data);

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      min_d        = min_q;
      max_d        = max_q;
      sum_d        = sum_q;
      stat_min_d   = stat_min_q;
      stat_max_d   = stat_max_q;
      stat_sum_d   = stat_sum_q;
      stat_frame_d = stat_frame_q;
      stat_valid_d = 1'b0;

      if (out_ready) out_valid_d = 1'b0;

      if (sync_clear) begin
         min_d = PX_MAX;
         max_d = '0;
         sum_d = '0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_d       = '{data: in_data, first: r_first, last_col: r_last_col, last_row: r_last_row};
         if (r_eof) begin
            stat_min_d   = px_min;
            stat_max_d   = px_max;
            stat_sum_d   = px_sum;
            stat_frame_d = stat_frame_q + 1'b1;
            stat_valid_d = 1'b1;
            min_d        = PX_MAX;
            max_d        = '0;
            sum_d        = '0;
         end else begin
            min_d = px_min;
            max_d = px_max;
            sum_d = px_sum;
         end
      end
   end

   // NOTE: the data path is reset too, because the published outputs must read as zero straight out of reset.
   always_ff @(posedge px_clk or negedge px_rst_n) begin
      if (!px_rst_n) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         min_q        <= PX_MAX;
         max_q        <= '0;
         sum_q        <= '0;
         stat_min_q   <= '0;
         stat_max_q   <= '0;
         stat_sum_q   <= '0;
         stat_frame_q <= '0;
         stat_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         min_q        <= min_d;
         max_q        <= max_d;
         sum_q        <= sum_d;
         stat_min_q   <= stat_min_d;
         stat_max_q   <= stat_max_d;
         stat_sum_q   <= stat_sum_d;
         stat_frame_q <= stat_frame_d;
         stat_valid_q <= stat_valid_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_q.data;
   assign out_first    = out_q.first;
   assign out_last_col = out_q.last_col;
   assign out_last_row = out_q.last_row;
   assign stat_valid   = stat_valid_q;
   assign stat_min     = stat_min_q;
   assign stat_max     = stat_max_q;
   assign stat_sum     = stat_sum_q;
   assign stat_frame   = stat_frame_q;

endmodule
